// File: rtl/alu_seq_if.sv
// Operation request / result bus between the issuing control FSM and alu_seq.
interface alu_seq_if #(
  parameter int DataWidth = 16,
  parameter int FlagBits  = 4
);
  logic                 InValid;
  logic                 InReady;
  logic [3:0]           FuncOp;
  logic [DataWidth-1:0] A;
  logic [DataWidth-1:0] B;
  logic [FlagBits-1:0]  IFlags;
  logic [DataWidth-1:0] Y;
  logic [FlagBits-1:0]  OFlags;
  logic                 OutValid;

  modport master (output InValid, FuncOp, A, B, IFlags,
                  input  InReady, Y, OFlags, OutValid);
  modport slave  (input  InValid, FuncOp, A, B, IFlags,
                  output InReady, Y, OFlags, OutValid);
endinterface

// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle arithmetic/logic/shift ops, iterative MUL/MULH and
// (when ALU_SEQ_DIV_EN is defined) restoring DIV/MOD, one bit per cycle.
module alu_seq #(
  parameter int DataWidth = 16,
  parameter int FlagBits  = 4
) (
  input  logic     Clock,
  input  logic     Reset_n,
  alu_seq_if.slave io
);
  localparam int W  = DataWidth;
  localparam int SW = $clog2(DataWidth);
  localparam int CW = $clog2(DataWidth + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t              state_reg;
  logic [W-1:0]        y_reg;
  logic [W-1:0]        mcand_reg;
  logic [FlagBits-1:0] flags_reg;
  logic                out_valid_reg;
  logic                op_lo_reg;
  logic [2*W-1:0]      acc_reg;
  logic [CW-1:0]       cnt_reg;
`ifdef ALU_SEQ_DIV_EN
  logic                divz_reg;
  logic [W:0]          div_shift;
  logic [W:0]          div_diff;
  logic [2*W-1:0]      div_next;
`endif

  logic           cin_eff;
  logic [SW-1:0]  sh;
  logic [W:0]     add_full, sub_full, shl_full, shr_full, asr_full;
  logic [W-1:0]   alu_y;
  logic           alu_c, alu_v;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next, iter_next;
  logic [W-1:0]   iter_y;
  logic           iter_c, iter_v;
  logic           unused_iflags;

  assign unused_iflags = ^io.IFlags;

  function automatic logic [FlagBits-1:0] pack_flags(input logic [W-1:0] y,
                                                      input logic c, input logic v);
    logic [FlagBits-1:0] f;
    f      = '0;
    f[3:0] = {y[W-1], (y == '0), c, v};
    return f;
  endfunction

  always_comb begin
    cin_eff  = io.FuncOp[0] & io.IFlags[1];
    sh       = io.B[SW-1:0];
    add_full = {1'b0, io.A} + {1'b0, io.B} + {{W{1'b0}}, cin_eff};
    sub_full = {1'b0, io.A} - {1'b0, io.B} - {{W{1'b0}}, cin_eff};
    // One guard bit on the far side of each shift captures the last bit out.
    shl_full = {1'b0, io.A} << sh;
    shr_full = {io.A, 1'b0} >> sh;
    asr_full = $unsigned($signed({io.A, 1'b0}) >>> sh);
    alu_y    = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (io.FuncOp)
      4'd0, 4'd1: begin
        alu_y = add_full[W-1:0];
        alu_c = add_full[W];
        alu_v = (io.A[W-1] == io.B[W-1]) && (add_full[W-1] != io.A[W-1]);
      end
      4'd2, 4'd3: begin
        alu_y = sub_full[W-1:0];
        alu_c = sub_full[W];
        alu_v = (io.A[W-1] != io.B[W-1]) && (sub_full[W-1] != io.A[W-1]);
      end
      4'd4:  alu_y = io.A & io.B;
      4'd5:  alu_y = io.A | io.B;
      4'd6:  alu_y = io.A ^ io.B;
      4'd7:  alu_y = ~io.A;
      4'd8: begin
        alu_y = shl_full[W-1:0];
        alu_c = (sh == '0) ? io.IFlags[1] : shl_full[W];
      end
      4'd9: begin
        alu_y = shr_full[W:1];
        alu_c = (sh == '0) ? io.IFlags[1] : shr_full[0];
      end
      4'd10: begin
        alu_y = asr_full[W:1];
        alu_c = (sh == '0) ? io.IFlags[1] : asr_full[0];
      end
      4'd11: alu_y = io.B;
`ifndef ALU_SEQ_DIV_EN
      4'd14, 4'd15: alu_v = 1'b1;
`endif
      default: ;
    endcase
  end

  // acc_reg holds {partial product, remaining multiplier} or {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
    mul_next  = {mul_sum, acc_reg[W-1:1]};
    iter_next = mul_next;
    iter_y    = op_lo_reg ? mul_next[2*W-1:W] : mul_next[W-1:0];
    iter_c    = !op_lo_reg && (mul_next[2*W-1:W] != '0);
    iter_v    = iter_c;
`ifdef ALU_SEQ_DIV_EN
    div_shift = {acc_reg[2*W-1:W], acc_reg[W-1]};
    div_diff  = div_shift - {1'b0, mcand_reg};
    div_next  = div_diff[W] ? {div_shift[W-1:0], acc_reg[W-2:0], 1'b0}
                            : {div_diff[W-1:0],  acc_reg[W-2:0], 1'b1};
    if (state_reg == S_DIV) begin
      iter_next = div_next;
      iter_y    = op_lo_reg ? div_next[2*W-1:W] : div_next[W-1:0];
      iter_c    = 1'b0;
      iter_v    = divz_reg;
    end
`endif
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= S_IDLE;
      y_reg         <= '0;
      flags_reg     <= '0;
      out_valid_reg <= 1'b0;
      op_lo_reg     <= 1'b0;
      mcand_reg     <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
`ifdef ALU_SEQ_DIV_EN
      divz_reg      <= 1'b0;
`endif
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (io.InValid) begin
            op_lo_reg <= io.FuncOp[0];
            cnt_reg   <= CW'(W);
            if (io.FuncOp == 4'd12 || io.FuncOp == 4'd13) begin
              state_reg <= S_MUL;
              acc_reg   <= {{W{1'b0}}, io.B};
              mcand_reg <= io.A;
            end
`ifdef ALU_SEQ_DIV_EN
            else if (io.FuncOp == 4'd14 || io.FuncOp == 4'd15) begin
              state_reg <= S_DIV;
              acc_reg   <= {{W{1'b0}}, io.A};
              mcand_reg <= io.B;
              divz_reg  <= (io.B == '0);
            end
`endif
            else begin
              y_reg         <= alu_y;
              flags_reg     <= pack_flags(alu_y, alu_c, alu_v);
              out_valid_reg <= 1'b1;
            end
          end
        end
        default: begin
          acc_reg <= iter_next;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_reg     <= S_IDLE;
            y_reg         <= iter_y;
            flags_reg     <= pack_flags(iter_y, iter_c, iter_v);
            out_valid_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign io.InReady  = (state_reg == S_IDLE);
  assign io.Y        = y_reg;
  assign io.OFlags   = flags_reg;
  assign io.OutValid = out_valid_reg;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational ALU.
- Adds registered outputs, a valid/ready input handshake, and iterative multi-cycle multiply and divide.
- Width is generic.
- Sits between the register-file read stage and write-back; the control FSM issues one operation at a time and waits for OutValid.

Parameters:
DataWidth, 16, operand/result width in bits (>= 4, power of 2)
FlagBits, 4, flag vector width; bit order [3]N [2]Z [1]C [0]V (bits above 3 driven 0)

Ports:
Clock  input  1  rising-edge clock
Reset_n  input  1  asynchronous, active-low reset
InValid  input  1  operation request
InReady  output  1  block can accept an operation (= state IDLE)
FuncOp  input  4  operation select, sampled on acceptance
A  input  DataWidth  operand A, sampled on acceptance
B  input  DataWidth  operand B, sampled on acceptance
IFlags  input  FlagBits  incoming flags; only C (bit 1) is used
Y  output  DataWidth  registered result, held until next result
OFlags  output  FlagBits  registered flags, updated with Y
OutValid  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (Reset_n low, asynchronous, may occur at any time including mid-iteration):
  - Y=0, OFlags=0, OutValid=0, state=IDLE, InReady=1.
  - Any in-flight operation is discarded.
- Acceptance: a rising edge with InValid=1 and InReady=1. FuncOp, A, B and IFlags[1] are latched. InValid is ignored while InReady=0; no queueing.
- No output back-pressure. OutValid is high for exactly one cycle. Y/OFlags hold their value afterwards.
- FuncOp encoding:
  - 0 ADD; 1 ADC (A+B+Cin); 2 SUB; 3 SBC (A-B-Cin).
  - 4 AND; 5 OR; 6 XOR; 7 NOT A.
  - 8 SHL; 9 SHR (logical); 10 ASR.
  - 11 PASS B.
  - 12 MUL (low half); 13 MULH (unsigned high half).
  - 14 DIV (unsigned quotient); 15 MOD (unsigned remainder).
- Ops 0-11 (single-cycle):
  - Y/OFlags/OutValid are registered on the acceptance edge; OutValid is high the following cycle.
  - State stays IDLE, so back-to-back issue every cycle is allowed.
- Ops 12-15: state MUL or DIV, InReady=0.
  - Shift-add multiply or restoring divide, one bit per cycle, iteration counter loaded with DataWidth.
  - Result is registered DataWidth cycles after the acceptance edge; OutValid is high in the cycle after that edge, and state returns to IDLE on the same edge.
  - Next acceptance is possible on the edge where OutValid is high.
- Flags, all ops: N = Y[DataWidth-1]; Z = (Y==0).
  - ADD/ADC: C = unsigned carry-out; V = signed overflow.
  - SUB/SBC: C = borrow (1 when A < B+Cin, unsigned); V = signed overflow.
  - Logical ops and PASS: C=0, V=0.
  - Shift amount = B[$clog2(DataWidth)-1:0]. C = last bit shifted out; amount 0 gives Y=A and C=Cin; V=0.
  - MUL: C=V=1 iff the high half of the 2*DataWidth product is nonzero. MULH: C=V=0.
  - DIV/MOD with B==0: quotient all ones, remainder A, V=1, C=0. Otherwise C=V=0.
- Width rule: internal add/sub is DataWidth+1 bits; the multiply accumulator is 2*DataWidth bits.

Optional Feature:
- Macro: ALU_SEQ_DIV_EN.
- Defined: the divider datapath and DIV state exist; ops 14/15 behave as above.
- Undefined: no divider logic is built. Ops 14/15 are treated as single-cycle illegal ops: Y=0, OFlags N=0 Z=1 C=0 V=1, OutValid the next cycle.

Test Plan:
- Assert Reset_n low 5 cycles into a MUL -> immediately Y=0x0000, OFlags=0, OutValid=0, InReady=1. After release, ADD 1+1 -> Y=0x0002.
- ADD 0x7FFF+0x0001 -> Y=0x8000, N=1 Z=0 C=0 V=1, OutValid one cycle after acceptance. ADC 0xFFFF+0x0000 with Cin=1 -> Y=0x0000, Z=1 C=1.
- SUB 0x0000-0x0001 -> Y=0xFFFF, N=1 C=1 V=0. Issue back-to-back with AND 0xF0F0&0x0FF0 -> Y=0x00F0 on consecutive OutValid pulses.
- MUL 0x0100*0x0100 (DataWidth=16) -> Y=0x0000, Z=1 C=1 V=1, OutValid 17 cycles after acceptance. InReady=0 throughout; an InValid asserted mid-operation is ignored. MULH same operands -> Y=0x0001.
- With ALU_SEQ_DIV_EN: DIV 0x0064/0x0007 -> 0x000E; MOD -> 0x0002; DIV 0x1234/0x0000 -> Y=0xFFFF, V=1. Without the macro: DIV -> Y=0, Z=1, V=1 after 1 cycle.
- SHL 0x8001 by 1 -> Y=0x0002, C=1. ASR 0x8000 by 4 -> Y=0xF800, N=1. SHR 0x1234 by 0 with Cin=1 -> Y=0x1234, C=1.
